avmm_rw_arbiter: RTL and testbench

Round-robin arbiter that shares the single kernel Avalon-MM read/write master (`avmm_0_rw_*`, fixed read latency, no waitrequest) among N internal load/store requesters of a generated component such as `bicg`. It issues at most one transaction per cycle, registers the master command, and tags in-flight reads so that each returning word goes back to the requester that issued it.

---
 rtl/avmm_arb_pkg.sv | 43 ++++
 rtl/avmm_rw_arbiter_if.sv | 46 ++++
 rtl/avmm_rd_tag_pipe.sv | 47 ++++
 rtl/avmm_rw_arbiter.sv | 148 ++++++++++++++
 tb/tb_avmm_rw_arbiter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/avmm_arb_pkg.sv
// Shared constants, tag/pick types and the round-robin search used by the
// Avalon-MM read/write arbiter.
package avmm_arb_pkg;

  localparam int N_REQ_DEF      = 4;
  localparam int ADDR_W_DEF     = 64;
  localparam int DATA_W_DEF     = 64;
  localparam int BE_W_DEF       = 8;
  localparam int RD_LATENCY_DEF = 2;

  // Indices are carried at the width needed for the largest requester count,
  // so the search and the tags are independent of N_REQ.
  localparam int N_REQ_MAX = 8;
  localparam int IDX_W     = 3;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
  } pick_t;

  // First set bit of active at or after ptr, wrapping.  Bits above N_REQ are
  // always zero, so wrapping modulo N_REQ_MAX equals wrapping modulo N_REQ.
  function automatic pick_t rr_pick(input logic [N_REQ_MAX-1:0] active,
                                    input logic [IDX_W-1:0]     ptr);
    pick_t            res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int k = N_REQ_MAX - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (active[idx]) begin
        res.found = 1'b1;
        res.index = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/avmm_rw_arbiter_if.sv
// Requester-side and Avalon-MM master-side signals of the read/write arbiter.
// The slave modport is the arbiter's view; master is the requesters/memory view.
interface avmm_rw_arbiter_if
  import avmm_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BE_W   = BE_W_DEF
);

  logic [N_REQ-1:0]        req_read;
  logic [N_REQ-1:0]        req_write;
  logic [N_REQ*ADDR_W-1:0] req_address;
  logic [N_REQ*BE_W-1:0]   req_byteenable;
  logic [N_REQ*DATA_W-1:0] req_writedata;
  logic [N_REQ-1:0]        req_grant;
  logic [N_REQ-1:0]        req_readdatavalid;
  logic [DATA_W-1:0]       req_readdata;

  logic [ADDR_W-1:0]       avmm_address;
  logic [BE_W-1:0]         avmm_byteenable;
  logic                    avmm_read;
  logic                    avmm_write;
  logic [DATA_W-1:0]       avmm_writedata;
  logic [DATA_W-1:0]       avmm_readdata;

  logic                    err_rw_conflict;

  modport slave (
    input  req_read, req_write, req_address, req_byteenable, req_writedata,
    input  avmm_readdata,
    output req_grant, req_readdatavalid, req_readdata,
    output avmm_address, avmm_byteenable, avmm_read, avmm_write, avmm_writedata,
    output err_rw_conflict
  );

  modport master (
    output req_read, req_write, req_address, req_byteenable, req_writedata,
    output avmm_readdata,
    input  req_grant, req_readdatavalid, req_readdata,
    input  avmm_address, avmm_byteenable, avmm_read, avmm_write, avmm_writedata,
    input  err_rw_conflict
  );

endinterface

// File: rtl/avmm_rd_tag_pipe.sv
// Fixed-depth shift register of {valid, id} read tags; the last stage lines up
// with the cycle in which the master returns read data.
module avmm_rd_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int ID_W  = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push_valid,
  input  logic [ID_W-1:0] push_id,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id
);

  logic [DEPTH-1:0] valid_reg;
  logic [ID_W-1:0]  id_reg [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            valid_reg[gi] <= 1'b0;
            id_reg[gi]    <= '0;
          end else begin
            valid_reg[gi] <= push_valid;
            id_reg[gi]    <= push_id;
          end
        end
      end else begin : g_body
        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            valid_reg[gi] <= 1'b0;
            id_reg[gi]    <= '0;
          end else begin
            valid_reg[gi] <= valid_reg[gi-1];
            id_reg[gi]    <= id_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign out_valid = valid_reg[DEPTH-1];
  assign out_id    = id_reg[DEPTH-1];

endmodule

// File: rtl/avmm_rw_arbiter.sv
// Round-robin arbiter sharing one fixed-latency Avalon-MM read/write master
// among N_REQ requesters, with tagged routing of returning read data.
module avmm_rw_arbiter
  import avmm_arb_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BE_W       = BE_W_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input logic               clock,
  input logic               reset,
  avmm_rw_arbiter_if.slave  bus
);

  logic [N_REQ-1:0]     active;
  logic [N_REQ_MAX-1:0] active_pad;
  pick_t                pick;

  logic [IDX_W-1:0]  rr_ptr_reg;
  logic [IDX_W-1:0]  rr_ptr_next;

  logic [ADDR_W-1:0] sel_address;
  logic [BE_W-1:0]   sel_byteenable;
  logic [DATA_W-1:0] sel_writedata;
  logic              sel_read;
  logic              sel_write;
  logic              issue_read;
  logic              issue_write;
  logic              conflict;

  logic [ADDR_W-1:0] avmm_address_reg;
  logic [BE_W-1:0]   avmm_byteenable_reg;
  logic              avmm_read_reg;
  logic              avmm_write_reg;
  logic [DATA_W-1:0] avmm_writedata_reg;
  logic              err_rw_conflict_reg;

  tag_t              push_tag;
  tag_t              out_tag;

  assign active = bus.req_read | bus.req_write;

  always_comb begin
    active_pad             = '0;
    active_pad[N_REQ-1:0]  = active;
    pick                   = rr_pick(active_pad, rr_ptr_reg);
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
      assign bus.req_grant[gi] = pick.found && (pick.index == IDX_W'(gi));
    end
  endgenerate

  // Command fields of the winning slice.
  always_comb begin
    sel_address    = '0;
    sel_byteenable = '0;
    sel_writedata  = '0;
    sel_read       = 1'b0;
    sel_write      = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick.index == IDX_W'(i)) begin
        sel_address    = bus.req_address[i*ADDR_W +: ADDR_W];
        sel_byteenable = bus.req_byteenable[i*BE_W +: BE_W];
        sel_writedata  = bus.req_writedata[i*DATA_W +: DATA_W];
        sel_read       = bus.req_read[i];
        sel_write      = bus.req_write[i];
      end
    end
  end

  // A simultaneous read+write resolves to the write; the read is dropped.
  assign issue_write = pick.found & sel_write;
  assign issue_read  = pick.found & sel_read & ~sel_write;
  assign conflict    = pick.found & sel_read & sel_write;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (pick.found) begin
      if (pick.index == IDX_W'(N_REQ - 1)) begin
        rr_ptr_next = '0;
      end else begin
        rr_ptr_next = pick.index + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_reg          <= '0;
      avmm_address_reg    <= '0;
      avmm_byteenable_reg <= '0;
      avmm_read_reg       <= 1'b0;
      avmm_write_reg      <= 1'b0;
      avmm_writedata_reg  <= '0;
      err_rw_conflict_reg <= 1'b0;
    end else begin
      rr_ptr_reg     <= rr_ptr_next;
      avmm_read_reg  <= issue_read;
      avmm_write_reg <= issue_write;
      if (pick.found) begin
        avmm_address_reg    <= sel_address;
        avmm_byteenable_reg <= sel_byteenable;
        avmm_writedata_reg  <= sel_writedata;
      end
      if (conflict) begin
        err_rw_conflict_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    push_tag       = '0;
    push_tag.valid = issue_read;
    push_tag.id    = pick.index;
  end

  // One stage for the command register plus RD_LATENCY stages of master latency.
  avmm_rd_tag_pipe #(
    .DEPTH (RD_LATENCY + 1),
    .ID_W  (IDX_W)
  ) u_tag_pipe (
    .clock      (clock),
    .reset      (reset),
    .push_valid (push_tag.valid),
    .push_id    (push_tag.id),
    .out_valid  (out_tag.valid),
    .out_id     (out_tag.id)
  );

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rdv
      assign bus.req_readdatavalid[gi] = out_tag.valid && (out_tag.id == IDX_W'(gi));
    end
  endgenerate

  assign bus.req_readdata    = bus.avmm_readdata;
  assign bus.avmm_address    = avmm_address_reg;
  assign bus.avmm_byteenable = avmm_byteenable_reg;
  assign bus.avmm_read       = avmm_read_reg;
  assign bus.avmm_write      = avmm_write_reg;
  assign bus.avmm_writedata  = avmm_writedata_reg;
  assign bus.err_rw_conflict = err_rw_conflict_reg;

endmodule

// File: tb/tb_avmm_rw_arbiter.sv
// Directed bench for avmm_rw_arbiter: 4 requesters, 64-bit bus, read latency 2.
module tb_avmm_rw_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int RL = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  avmm_rw_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) bus ();

  avmm_rw_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .RD_LATENCY(RL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic [63:0] a, input logic [7:0] be,
                         input logic [63:0] wd);
    bus.req_address[i*AW +: AW]    = a;
    bus.req_byteenable[i*BW +: BW] = be;
    bus.req_writedata[i*DW +: DW]  = wd;
  endtask

  // Called just after a rising edge: drive requests for this cycle, check the
  // combinational grant and the routed read-valid, then move to the next cycle.
  task automatic cyc(input logic [3:0] rd, input logic [3:0] wr, input logic [3:0] exp_g,
                     input logic [3:0] exp_v, input string tag);
    bus.req_read  = rd;
    bus.req_write = wr;
    #1;
    chk({tag, " grant"}, 64'(bus.req_grant), 64'(exp_g));
    chk({tag, " rdvalid"}, 64'(bus.req_readdatavalid), 64'(exp_v));
    $display("%s: read=%b write=%b grant=%b rdvalid=%b", tag, rd, wr,
             bus.req_grant, bus.req_readdatavalid);
    tick();
  endtask

  task automatic chk_cmd(input string tag, input logic rd, input logic wr,
                         input logic [63:0] a);
    chk({tag, " avmm_read"}, 64'(bus.avmm_read), 64'(rd));
    chk({tag, " avmm_write"}, 64'(bus.avmm_write), 64'(wr));
    chk({tag, " avmm_address"}, bus.avmm_address, a);
  endtask

  initial begin
    bus.req_read       = '0;
    bus.req_write      = '0;
    bus.req_address    = '0;
    bus.req_byteenable = '0;
    bus.req_writedata  = '0;
    bus.avmm_readdata  = '0;

    // Reset state
    tick();
    chk("rst avmm_read", 64'(bus.avmm_read), 64'd0);
    chk("rst avmm_write", 64'(bus.avmm_write), 64'd0);
    chk("rst avmm_address", bus.avmm_address, 64'd0);
    chk("rst avmm_byteenable", 64'(bus.avmm_byteenable), 64'd0);
    chk("rst avmm_writedata", bus.avmm_writedata, 64'd0);
    chk("rst rdvalid", 64'(bus.req_readdatavalid), 64'd0);
    chk("rst err", 64'(bus.err_rw_conflict), 64'd0);
    tick();
    reset = 1'b0;

    // Single read from requester 2
    set_cmd(2, 64'h1000, 8'hFF, 64'h0);
    cyc(4'b0100, 4'b0000, 4'b0100, 4'b0000, "t1 c0");
    chk_cmd("t1 c1", 1'b1, 1'b0, 64'h1000);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "t1 c1");
    chk_cmd("t1 c2", 1'b0, 1'b0, 64'h1000);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "t1 c2");
    bus.avmm_readdata = 64'hDEAD;
    #1;
    chk("t1 c3 readdata", bus.req_readdata, 64'hDEAD);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0100, "t1 c3");
    bus.avmm_readdata = '0;
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "t1 c4");

    // Fairness from reset: everyone holds a read
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_cmd(i, 64'h1000 * (i + 1), 8'hFF, 64'h0);
    for (int c = 0; c < 8; c++) begin
      logic [3:0] rd;
      logic [3:0] eg;
      logic [3:0] ev;
      rd = (c <= 4) ? 4'b1111 : 4'b0000;
      eg = (c <= 4) ? 4'(1 << (c % 4)) : 4'b0000;
      ev = (c >= 3) ? 4'(1 << ((c - 3) % 4)) : 4'b0000;
      bus.avmm_readdata = 64'h100 + 64'(c);
      #1;
      if (c >= 3) chk($sformatf("t2 c%0d readdata", c), bus.req_readdata, 64'h100 + 64'(c));
      cyc(rd, 4'b0000, eg, ev, $sformatf("t2 c%0d", c));
      if (c <= 4) chk_cmd($sformatf("t2 c%0d", c + 1), 1'b1, 1'b0, 64'h1000 * ((c % 4) + 1));
      else        chk($sformatf("t2 c%0d avmm_read", c + 1), 64'(bus.avmm_read), 64'd0);
    end
    bus.avmm_readdata = '0;

    // Write from requester 1 (pointer now at 1)
    set_cmd(1, 64'h20, 8'h0F, 64'h55AA);
    cyc(4'b0000, 4'b0010, 4'b0010, 4'b0000, "t3 c0");
    chk_cmd("t3 c1", 1'b0, 1'b1, 64'h20);
    chk("t3 c1 byteenable", 64'(bus.avmm_byteenable), 64'h0F);
    chk("t3 c1 writedata", bus.avmm_writedata, 64'h55AA);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "t3 c1");
    chk_cmd("t3 c2 hold", 1'b0, 1'b0, 64'h20);
    chk("t3 c2 writedata hold", bus.avmm_writedata, 64'h55AA);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "t3 c2");
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "t3 c3");
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "t3 c4");

    // Mixed stream: reads from 0 and 3, write from 1 (pointer now at 2)
    set_cmd(0, 64'h100, 8'hFF, 64'h0);
    set_cmd(3, 64'h300, 8'hFF, 64'h0);
    set_cmd(1, 64'h10, 8'h03, 64'hABCD);
    cyc(4'b0001, 4'b0000, 4'b0001, 4'b0000, "t4 c0");
    chk_cmd("t4 c1", 1'b1, 1'b0, 64'h100);
    cyc(4'b1000, 4'b0010, 4'b0010, 4'b0000, "t4 c1");
    chk_cmd("t4 c2", 1'b0, 1'b1, 64'h10);
    set_cmd(0, 64'h104, 8'hFF, 64'h0);
    cyc(4'b1001, 4'b0000, 4'b1000, 4'b0000, "t4 c2");
    chk_cmd("t4 c3", 1'b1, 1'b0, 64'h300);
    cyc(4'b0001, 4'b0000, 4'b0001, 4'b0001, "t4 c3");
    chk_cmd("t4 c4", 1'b1, 1'b0, 64'h104);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "t4 c4");
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b1000, "t4 c5");
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0001, "t4 c6");
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "t4 c7");

    // Read+write conflict on requester 0
    chk("t5 err before", 64'(bus.err_rw_conflict), 64'd0);
    set_cmd(0, 64'h40, 8'hFF, 64'h77);
    cyc(4'b0001, 4'b0001, 4'b0001, 4'b0000, "t5 c0");
    chk_cmd("t5 c1", 1'b0, 1'b1, 64'h40);
    chk("t5 c1 writedata", bus.avmm_writedata, 64'h77);
    chk("t5 c1 err", 64'(bus.err_rw_conflict), 64'd1);
    for (int c = 1; c < 5; c++) cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, $sformatf("t5 c%0d", c));
    chk("t5 err sticky", 64'(bus.err_rw_conflict), 64'd1);

    // Reset one cycle after a read grant
    set_cmd(2, 64'h2000, 8'hFF, 64'h0);
    cyc(4'b0100, 4'b0000, 4'b0100, 4'b0000, "t6 c0");
    chk_cmd("t6 c1", 1'b1, 1'b0, 64'h2000);
    reset = 1'b1;
    #1;
    chk_cmd("t6 rst", 1'b0, 1'b0, 64'h0);
    chk("t6 rst byteenable", 64'(bus.avmm_byteenable), 64'd0);
    chk("t6 rst writedata", bus.avmm_writedata, 64'd0);
    chk("t6 rst err", 64'(bus.err_rw_conflict), 64'd0);
    chk("t6 rst rdvalid", 64'(bus.req_readdatavalid), 64'd0);
    chk("t6 rst readdata", bus.req_readdata, 64'd0);
    tick();
    chk("t6 c2 rdvalid", 64'(bus.req_readdatavalid), 64'd0);
    tick();
    reset = 1'b0;
    bus.avmm_readdata = 64'hBEEF;
    cyc(4'b1111, 4'b0000, 4'b0001, 4'b0000, "t6 c3");
    bus.avmm_readdata = '0;
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "t6 c4");
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, "t6 c5");
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0001, "t6 c6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
